// File: rtl/reg_access_pkg.sv
// Shared constants and types for the master-side register-access initiator.
// State encodings stay as plain 3-bit localparams so legacy code can use them.
package reg_access_pkg;

    localparam int DATA_W       = 32;
    localparam int REG_NUM_BITS = 4;

    // Number of cycles between the read strobe and a valid readback word.
    localparam int RDBK_LAT   = 1;
    localparam int WAIT_CNT_W = (RDBK_LAT > 1) ? $clog2(RDBK_LAT) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/reg_access_master_if.sv
// Request/response handshake plus the shared bus toward the register block.
// The master modport is the initiator; the slave modport is its environment.
interface reg_access_master_if;
    import reg_access_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    logic [DATA_W-1:0] reg_data_out;
    logic [DATA_W-1:0] reg_data_in;
    logic              reg_num_le;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic              reg_illegal;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready, reg_data_in, reg_illegal,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output reg_data_out, reg_num_le, reg_wr_en, reg_rd_en
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready, reg_data_in, reg_illegal,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  reg_data_out, reg_num_le, reg_wr_en, reg_rd_en
    );

endinterface

// File: rtl/reg_access_master.sv
// Sequences address load, legality check, one-cycle write/read strobe and
// readback capture for each register request; every output is a flop.
module reg_access_master
    import reg_access_pkg::*;
#(
    parameter bit ADDR_CACHE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    reg_access_master_if.master bus
);

    logic [2:0]            state_q, state_d;
    req_t                  req_q, req_d;
    logic                  cache_valid_q, cache_valid_d;
    logic [DATA_W-1:0]     cache_addr_q, cache_addr_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]     reg_data_out_q, reg_data_out_d;
    logic                  reg_num_le_q, reg_num_le_d;
    logic                  reg_wr_en_q, reg_wr_en_d;
    logic                  reg_rd_en_q, reg_rd_en_d;

    logic req_fire;
    logic rsp_fire;
    logic cache_hit;

    assign req_fire  = bus.req_valid && req_ready_q;
    assign rsp_fire  = rsp_valid_q && bus.rsp_ready;
    // Only numbers that passed the legality check are ever cached.
    assign cache_hit = ADDR_CACHE && cache_valid_q && (bus.req_addr == cache_addr_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d       = state_q;
        req_d         = req_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_error_d   = rsp_error_q;
        rsp_rdata_d   = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    req_d.write = bus.req_write;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    state_d     = cache_hit ? ST_ACCESS : ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.reg_illegal) begin
                    cache_valid_d = 1'b0;
                    rsp_error_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cache_valid_d = 1'b1;
                    cache_addr_d  = req_q.addr;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (req_q.write) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = WAIT_CNT_W'(RDBK_LAT - 1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_rdata_d = bus.reg_data_in;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are valid the same
    // cycle the state register enters that state.
    always_comb begin
        req_ready_d    = (state_d == ST_IDLE);
        rsp_valid_d    = (state_d == ST_RESP);
        reg_num_le_d   = (state_d == ST_LOAD);
        reg_wr_en_d    = (state_d == ST_ACCESS) &&  req_d.write;
        reg_rd_en_d    = (state_d == ST_ACCESS) && !req_d.write;
        reg_data_out_d = reg_data_out_q;
        if (state_d == ST_LOAD) begin
            reg_data_out_d = req_d.addr;
        end else if (state_d == ST_ACCESS) begin
            reg_data_out_d = req_d.wdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q        <= ST_IDLE;
            cache_valid_q  <= 1'b0;
            wait_cnt_q     <= '0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            reg_data_out_q <= '0;
            reg_num_le_q   <= 1'b0;
            reg_wr_en_q    <= 1'b0;
            reg_rd_en_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cache_valid_q  <= cache_valid_d;
            wait_cnt_q     <= wait_cnt_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_error_q    <= rsp_error_d;
            rsp_rdata_q    <= rsp_rdata_d;
            reg_data_out_q <= reg_data_out_d;
            reg_num_le_q   <= reg_num_le_d;
            reg_wr_en_q    <= reg_wr_en_d;
            reg_rd_en_q    <= reg_rd_en_d;
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed while
    // the state or cache_valid_q says they hold something meaningful.
    always_ff @(posedge clk) begin
        req_q        <= req_d;
        cache_addr_q <= cache_addr_d;
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.reg_data_out = reg_data_out_q;
    assign bus.reg_num_le   = reg_num_le_q;
    assign bus.reg_wr_en    = reg_wr_en_q;
    assign bus.reg_rd_en    = reg_rd_en_q;

endmodule

// File: tb/tb_reg_access_master.sv
// Bench for reg_access_master: one cached and one uncached instance, each with
// a register-block model, checked against a request-level reference model.
module tb_reg_access_master;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #4 clk = ~clk;

    reg_access_master_if bc ();
    reg_access_master_if bn ();

    reg_access_master #(.ADDR_CACHE(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(bc.master));
    reg_access_master #(.ADDR_CACHE(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(bn.master));

    // Shared stimulus; sel picks which instance sees req_valid/rsp_ready.
    logic        sel       = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;

    assign bc.req_valid = req_valid & ~sel;
    assign bn.req_valid = req_valid &  sel;
    assign bc.rsp_ready = rsp_ready & ~sel;
    assign bn.rsp_ready = rsp_ready &  sel;
    assign bc.req_write = req_write;
    assign bn.req_write = req_write;
    assign bc.req_addr  = req_addr;
    assign bn.req_addr  = req_addr;
    assign bc.req_wdata = req_wdata;
    assign bn.req_wdata = req_wdata;

    logic        o_req_ready, o_rsp_valid, o_err, o_le, o_wr, o_rd;
    logic [31:0] o_rdata, o_bus;
    assign o_req_ready = sel ? bn.req_ready    : bc.req_ready;
    assign o_rsp_valid = sel ? bn.rsp_valid    : bc.rsp_valid;
    assign o_err       = sel ? bn.rsp_error    : bc.rsp_error;
    assign o_rdata     = sel ? bn.rsp_rdata    : bc.rsp_rdata;
    assign o_le        = sel ? bn.reg_num_le   : bc.reg_num_le;
    assign o_wr        = sel ? bn.reg_wr_en    : bc.reg_wr_en;
    assign o_rd        = sel ? bn.reg_rd_en    : bc.reg_rd_en;
    assign o_bus       = sel ? bn.reg_data_out : bc.reg_data_out;

    // Register block models: 16 registers decoded from bits [3:0] only.
    logic [31:0] blk_num_c = '0, blk_rdbk_c = '0;
    logic [31:0] blk_num_n = '0, blk_rdbk_n = '0;
    logic [31:0] blk_regs_c [16] = '{default: '0};
    logic [31:0] blk_regs_n [16] = '{default: '0};

    always @(posedge clk) begin
        if (bc.reg_num_le) blk_num_c <= bc.reg_data_out;
        if (bc.reg_wr_en)  blk_regs_c[blk_num_c[3:0]] <= bc.reg_data_out;
        if (bc.reg_rd_en)  blk_rdbk_c <= blk_regs_c[blk_num_c[3:0]];
        if (bn.reg_num_le) blk_num_n <= bn.reg_data_out;
        if (bn.reg_wr_en)  blk_regs_n[blk_num_n[3:0]] <= bn.reg_data_out;
        if (bn.reg_rd_en)  blk_rdbk_n <= blk_regs_n[blk_num_n[3:0]];
    end
    assign bc.reg_illegal = |blk_num_c[31:4];
    assign bn.reg_illegal = |blk_num_n[31:4];
    assign bc.reg_data_in = blk_rdbk_c;
    assign bn.reg_data_in = blk_rdbk_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Global strobe monitors, judged once at the end.
    int excl_viol  = 0;
    int illegal_wr = 0;
    always @(negedge clk) begin
        if (int'(bc.reg_num_le) + int'(bc.reg_wr_en) + int'(bc.reg_rd_en) > 1) excl_viol++;
        if (int'(bn.reg_num_le) + int'(bn.reg_wr_en) + int'(bn.reg_rd_en) > 1) excl_viol++;
        if (bc.reg_wr_en && (blk_num_c[31:4] != 28'd0)) illegal_wr++;
        if (bn.reg_wr_en && (blk_num_n[31:4] != 28'd0)) illegal_wr++;
    end

    // Reference model: register contents and the address cache of the cached instance.
    logic [31:0] m_regs [2][16];
    bit          m_cv;
    logic [31:0] m_ca;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on the selected instance; entered and left just after a negedge.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input bit early, output int t_acc);
        bit          legal, cached;
        int          exp_lat, k, le_c, le_at, acc_c, acc_at, stall_strb;
        logic [31:0] exp_rdata, le_bus, acc_bus;
        bit          saw_wr, saw_rd;

        legal     = (addr[31:4] == 28'd0);
        cached    = !sel && m_cv && (m_ca == addr);
        if (cached)      exp_lat = wr ? 2 : 3;
        else if (!legal) exp_lat = 3;
        else             exp_lat = wr ? 4 : 5;
        exp_rdata = (!wr && legal) ? m_regs[int'(sel)][addr[3:0]] : 32'd0;

        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        k = 0;
        while (!o_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        t_acc = cyc;
        check("req_ready", o_req_ready, 1);
        if (!o_req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;

        le_c = 0; le_at = 0; acc_c = 0; acc_at = 0; le_bus = '0; acc_bus = '0;
        saw_wr = 0; saw_rd = 0;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_le) begin
                le_c++; le_at = k; le_bus = o_bus;
            end
            if (o_wr || o_rd) begin
                acc_c++; acc_at = k; acc_bus = o_bus;
                saw_wr |= o_wr; saw_rd |= o_rd;
            end
            if (o_rsp_valid) break;
        end

        check("rsp_latency", k, exp_lat);
        check("rsp_error", o_err, !legal);
        check("rsp_rdata", o_rdata, exp_rdata);
        check("num_le_count", le_c, cached ? 0 : 1);
        if (!cached) begin
            check("num_le_cycle", le_at, 1);
            check("num_le_bus", le_bus, addr);
        end
        check("access_count", acc_c, legal ? 1 : 0);
        if (legal) begin
            check("access_cycle", acc_at, cached ? 1 : 3);
            check("access_dir", {saw_wr, saw_rd}, wr ? 2 : 1);
            if (wr) check("wr_bus", acc_bus, wd);
        end

        stall_strb = 0;
        if (early) req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", o_rsp_valid, 1);
            check("stall_rdata", o_rdata, exp_rdata);
            check("stall_req_ready", o_req_ready, 0);
            stall_strb += int'(o_le) + int'(o_wr) + int'(o_rd);
        end
        if (hold > 0) check("stall_strobes", stall_strb, 0);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_cleared", o_rsp_valid, 0);
        check("err_cleared", o_err, 0);
        check("rdata_cleared", o_rdata, 0);
        check("next_req_ready", o_req_ready, 1);

        if (wr && legal) m_regs[int'(sel)][addr[3:0]] = wd;
        if (!sel && !cached) begin
            if (legal) begin
                m_cv = 1'b1;
                m_ca = addr;
            end else begin
                m_cv = 1'b0;
            end
        end
    endtask

    // Start a write and pull reset while its write strobe is on the bus.
    task automatic reset_in_access(input logic [31:0] addr, input logic [31:0] wd);
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        check("ria_ready", o_req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("ria_in_access", o_wr, 1);
        reset = 1'b1;
        @(negedge clk);
        check("ria_strobes", {o_le, o_wr, o_rd}, 0);
        check("ria_rsp_valid", o_rsp_valid, 0);
        check("ria_req_ready", o_req_ready, 0);
        reset = 1'b0;
        m_cv  = 1'b0;
        m_regs[int'(sel)][addr[3:0]] = wd;
        repeat (3) begin
            @(negedge clk);
            check("ria_no_rsp", o_rsp_valid, 0);
        end
    endtask

    initial begin
        int          t0, t1;
        bit          wr;
        logic [31:0] a;

        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 16; r++) m_regs[s][r] = '0;
        m_cv = 1'b0;
        m_ca = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", bc.req_ready, 0);
        check("rst_rsp_valid", bc.rsp_valid, 0);
        check("rst_rsp_error", bc.rsp_error, 0);
        check("rst_rsp_rdata", bc.rsp_rdata, 0);
        check("rst_bus", bc.reg_data_out, 0);
        check("rst_strobes", {bc.reg_num_le, bc.reg_wr_en, bc.reg_rd_en}, 0);
        check("rst_n_strobes", {bn.reg_num_le, bn.reg_wr_en, bn.reg_rd_en}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready_c", bc.req_ready, 1);
        check("idle_ready_n", bn.req_ready, 1);

        // Cached instance: load, cache hit, illegal number, long stall.
        sel = 1'b0;
        do_req(1'b1, 32'h5,  32'hDEADBEEF, 0, 1'b0, t0);
        do_req(1'b0, 32'h5,  32'h0,        0, 1'b0, t0);
        do_req(1'b1, 32'h15, 32'h12345678, 0, 1'b0, t0);
        do_req(1'b0, 32'h5,  32'h0,        10, 1'b1, t0);
        do_req(1'b0, 32'h5,  32'h0,        0, 1'b0, t0);

        reset_in_access(32'h7, 32'hA5A5_0007);
        do_req(1'b1, 32'h7, 32'h0BAD_F00D, 0, 1'b0, t0);
        do_req(1'b0, 32'h7, 32'h0,         0, 1'b0, t0);

        do_req(1'b1, 32'h8, 32'h1111_2222, 0, 1'b0, t0);
        do_req(1'b1, 32'h9, 32'h3333_4444, 0, 1'b0, t1);
        check("b2b_spacing_c", t1 - t0, 5);

        // Uncached instance: every access reloads the number.
        sel = 1'b1;
        do_req(1'b1, 32'hA, 32'hCAFE_0001, 0, 1'b0, t0);
        do_req(1'b1, 32'hA, 32'hCAFE_0002, 0, 1'b0, t1);
        check("b2b_spacing_n", t1 - t0, 5);
        do_req(1'b0, 32'hA, 32'h0, 0, 1'b0, t0);
        do_req(1'b0, 32'hA, 32'h0, 0, 1'b0, t0);

        for (int n = 0; n < 80; n++) begin
            sel = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                a = {28'($urandom_range(1, 1000)), 4'($urandom_range(0, 15))};
            else if ($urandom_range(0, 1) == 0)
                a = 32'($urandom_range(0, 3));
            else
                a = 32'($urandom_range(0, 15));
            do_req(wr, a, $urandom, $urandom_range(0, 3), 1'b0, t0);
        end

        check("strobe_exclusive", excl_viol, 0);
        check("illegal_write", illegal_wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_access_master.md
# reg_access_master

Initiator side of the master-FPGA register-access interface. Accepts register read/write requests on a valid/ready port and sequences the address-load, write or read strobes and the 32-bit shared data bus toward the register block. Captures readback data, checks the illegal-register flag before any access, and returns one response per request. Sits in the master-side logic, between the command/link decoder and the register block.

## Interface
- ADDR_CACHE, 1: when 1, skip the address-load phase if the request address equals the last successfully loaded address.
- clk  in  1  125 MHz interconnect clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  register number; bits [31:4] must be zero for a legal access.
- req_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_rdata  out  32  readback data; 0 for writes and errors.
- rsp_error  out  1  1 = register number illegal, no access performed.
- reg_data_out  out  32  shared bus to register block rx_data (address or write data).
- reg_data_in  in  32  register block tx_data (readback).
- reg_num_le  out  1  load register number strobe.
- reg_wr_en  out  1  write strobe.
- reg_rd_en  out  1  read strobe.
- reg_illegal  in  1  register block illegal_reg_num flag (combinational from its loaded number).

## Operation
- All outputs registered. Reset values: req_ready=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, reg_data_out=0, all strobes 0, state IDLE, cache invalid.
- States: IDLE, LOAD, CHECK, ACCESS, WAIT, RESP.
- IDLE: req_ready=1. On handshake latch op/addr/wdata, deassert req_ready. If ADDR_CACHE and cache valid and addr matches the cached value, go to ACCESS; otherwise go to LOAD.
- LOAD: reg_num_le=1, reg_data_out=addr, for one cycle. Then go to CHECK.
- CHECK: no strobes. Sample reg_illegal. If it is 1, invalidate the cache, set rsp_error=1, and go to RESP. Otherwise store addr in the cache, mark it valid, and go to ACCESS.
- ACCESS: for one cycle drive reg_data_out=wdata with reg_wr_en=1 (write) or reg_rd_en=1 (read). Write goes to RESP. Read goes to WAIT.
- WAIT: the register block readback register updates at the end of the ACCESS cycle. Capture reg_data_in into rsp_rdata at the end of WAIT, then go to RESP.
- RESP: rsp_valid=1, with outputs stable until rsp_ready. On handshake clear rsp_valid/rsp_error/rsp_rdata and go to IDLE.
- reg_wr_en is never asserted for an illegal number, because the register block decodes only bits [3:0] and would otherwise alias the write.
- The strobes are mutually exclusive and each lasts exactly one cycle per request.

## Timing
- Request accepted at edge 0.
- Uncached write: LOAD cycle 1, CHECK 2, ACCESS 3, rsp_valid from cycle 4.
- Uncached read: rsp_valid from cycle 5.
- Cached: write rsp_valid at cycle 2, read at cycle 3.
- Illegal: rsp_valid with rsp_error at cycle 3.
- rsp_ready held high: IDLE follows the response cycle. Back-to-back uncached writes take 5 cycles each.
- The next req_ready comes one cycle after the response handshake. There is no overlap between requests.
- Reset at any cycle returns to IDLE next edge: strobes low, cache invalid, pending response dropped.
- reg_illegal is ignored outside CHECK.

## Structure
- Shared package reg_access_pkg holds:
  - state encoding (3-bit localparams);
  - REG_NUM_BITS=4;
  - the readback latency constant RDBK_LAT=1, which sets the WAIT length.
- Single flat module. No sub-module is natural.

## Test plan
- Write addr 0x5, data 0xDEADBEEF, rsp_ready=1: reg_num_le at cycle 1 with bus=0x5; reg_wr_en at cycle 3 with bus=0xDEADBEEF; rsp_valid at cycle 4 with error=0.
- Read addr 0x5 after the write above, ADDR_CACHE=1: no reg_num_le; reg_rd_en at cycle 1; rsp_rdata=0xDEADBEEF at cycle 3.
- Write addr 0x15, with a model asserting reg_illegal: reg_num_le fires; reg_wr_en never fires; rsp_error=1 at cycle 3. A following request to 0x5 reloads the address.
- rsp_ready held low for 10 cycles on a read: rsp_valid/rsp_rdata stable, req_ready=0 throughout. A new req_valid is not accepted until one cycle after the handshake.
- Reset asserted during ACCESS of a write: all strobes 0 next cycle, no response, and the next request to the same address performs LOAD.
- ADDR_CACHE=0, two reads to 0xA: both perform LOAD+CHECK, and each rsp_valid arrives 5 cycles after acceptance.
